// File: rtl/video_field_addr_pkg.sv
// Shared constants and FSM encoding for the video field addresser.
// Holds default active-area geometry, counter widths and the state type.
// Imported by video_field_addresser and video_edge_det.
package video_field_addr_pkg;

    localparam int ACTIVE_PIXELS_DEF = 702;
    localparam int ACTIVE_LINES_DEF  = 288;
    localparam int COL_W             = 10;
    localparam int ROW_W             = 9;
    localparam int ADDR_W            = ROW_W + 1 + COL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIELD = 2'd2,
        ST_LINE  = 2'd3
    } vfa_state_t;

endpackage

// File: rtl/video_edge_det.sv
// Rise/fall pulse detector for a level input (one register of history).
// Ports: clk, rst (sync active-high), sig (level in), rise/fall (pulses).
// Pulses are combinational from sig and the registered previous value.
module video_edge_det
    import video_field_addr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= sig;
    end

    assign rise = sig & ~prev;
    assign fall = ~sig & prev;

endmodule

// File: rtl/video_field_addresser.sv
// Video field addresser: turns decoder frame/line/pixel strobes into
// registered pixels with a {row, field, col} write address, 1-clock latency.
// Ports: clk, rst (sync active-high), in_frame_valid/in_line_valid/
//   in_data_valid/in_data in; video_frame_valid/video_line_valid/
//   video_data_valid/video_data_in/video_address and pix_overflow/
//   line_overflow out.
// Optional build macro VIDEO_FIELD_ADDR_ERR_FLAGS_EN enables the sticky
// overflow flags; without it both flags are tied low.
module video_field_addresser
    import video_field_addr_pkg::*;
#(
    parameter int ACTIVE_PIXELS = ACTIVE_PIXELS_DEF,
    parameter int ACTIVE_LINES  = ACTIVE_LINES_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_frame_valid,
    input  logic              in_line_valid,
    input  logic              in_data_valid,
    input  logic [7:0]        in_data,
    output logic              video_frame_valid,
    output logic              video_line_valid,
    output logic              video_data_valid,
    output logic [7:0]        video_data_in,
    output logic [ADDR_W-1:0] video_address,
    output logic              pix_overflow,
    output logic              line_overflow
);

    localparam logic [COL_W-1:0] PIX_LIM  = COL_W'(ACTIVE_PIXELS);
    localparam logic [ROW_W-1:0] LINE_LIM = ROW_W'(ACTIVE_LINES);

    logic frame_rise, frame_fall, line_rise, line_fall;

    video_edge_det u_frame_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (in_frame_valid),
        .rise (frame_rise),
        .fall (frame_fall)
    );

    video_edge_det u_line_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (in_line_valid),
        .rise (line_rise),
        .fall (line_fall)
    );

    vfa_state_t       state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             field;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a frame fall wins over any line edge in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!in_frame_valid) state_nxt = ST_ARMED;
            ST_ARMED: if (frame_rise)      state_nxt = ST_FIELD;
            ST_FIELD: begin
                if (frame_fall)     state_nxt = ST_ARMED;
                else if (line_rise) state_nxt = ST_LINE;
            end
            ST_LINE: begin
                if (frame_fall)     state_nxt = ST_ARMED;
                else if (line_fall) state_nxt = ST_FIELD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: pixel window includes the cycle the line rises in FIELD
    logic line_win, field_active;
    always_comb begin
        line_win     = 1'b0;
        field_active = 1'b0;
        case (state)
            ST_FIELD: begin
                field_active = 1'b1;
                line_win     = line_rise & in_frame_valid;
            end
            ST_LINE: begin
                field_active = 1'b1;
                line_win     = in_line_valid & in_frame_valid;
            end
            default: ;
        endcase
    end

    // A strobe coincident with the line rise must see col already cleared
    logic [COL_W-1:0] eff_col;
    logic             col_ok, row_ok, strobe, accept;

    assign eff_col = line_rise ? '0 : col;
    assign col_ok  = eff_col < PIX_LIM;
    assign row_ok  = row < LINE_LIM;
    assign strobe  = line_win & in_data_valid;
    assign accept  = strobe & col_ok & row_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            col               <= '0;
            row               <= '0;
            field             <= 1'b0;
            video_frame_valid <= 1'b0;
            video_line_valid  <= 1'b0;
            video_data_valid  <= 1'b0;
            video_data_in     <= '0;
            video_address     <= '0;
        end else begin
            video_frame_valid <= in_frame_valid;
            video_line_valid  <= in_line_valid;
            video_data_valid  <= accept;

            // Address and data hold their last accepted value between pulses
            if (accept) begin
                video_data_in <= in_data;
                video_address <= {row, field, eff_col};
                col           <= eff_col + COL_W'(1);
            end else if (line_rise) begin
                col <= '0;
            end

            // Row counts completed lines and parks at the limit
            if (frame_rise)
                row <= '0;
            else if (state == ST_LINE && line_fall && row != LINE_LIM)
                row <= row + ROW_W'(1);

            // Independent of the row update so a joint line/frame fall does both
            if (field_active && frame_fall)
                field <= ~field;
        end
    end

`ifdef VIDEO_FIELD_ADDR_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_overflow  <= 1'b0;
            line_overflow <= 1'b0;
        end else begin
            if (strobe && !col_ok) pix_overflow  <= 1'b1;
            if (strobe && !row_ok) line_overflow <= 1'b1;
        end
    end
`else
    assign pix_overflow  = 1'b0;
    assign line_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_video_field_addresser.sv
// Bench for video_field_addresser with a reduced active area (8 px x 4 lines).
// Stimulus pushes expected {address, data} per accepted strobe; a monitor
// pops and compares on every video_data_valid pulse.
module tb_video_field_addresser;

    localparam int AP = 8;
    localparam int AL = 4;

`ifdef VIDEO_FIELD_ADDR_ERR_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_frame_valid, in_line_valid, in_data_valid;
    logic [7:0]  in_data;
    logic        video_frame_valid, video_line_valid, video_data_valid;
    logic [7:0]  video_data_in;
    logic [19:0] video_address;
    logic        pix_overflow, line_overflow;

    video_field_addresser #(.ACTIVE_PIXELS(AP), .ACTIVE_LINES(AL)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_frame_valid    (in_frame_valid),
        .in_line_valid     (in_line_valid),
        .in_data_valid     (in_data_valid),
        .in_data           (in_data),
        .video_frame_valid (video_frame_valid),
        .video_line_valid  (video_line_valid),
        .video_data_valid  (video_data_valid),
        .video_data_in     (video_data_in),
        .video_address     (video_address),
        .pix_overflow      (pix_overflow),
        .line_overflow     (line_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c, input logic f);
        return 8'((r * 37 + c * 5 + int'(f)) & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input int c, input logic f);
        exp_t e;
        e.addr = {9'(r), f, 10'(c)};
        e.data = pix(r, c, f);
        exp_q.push_back(e);
    endtask

    // One line: the first strobe coincides with the line rise
    task automatic do_line(input int n, input int r, input logic f, input logic live,
                           input logic end_frame);
        in_line_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data_valid = 1'b1;
            in_data       = pix(r, i, f);
            if (live && i < AP && r < AL) push(r, i, f);
            tick();
        end
        in_data_valid = 1'b0;
        tick();
        in_line_valid = 1'b0;
        if (end_frame) in_frame_valid = 1'b0;
        tick();
        tick();
    endtask

    // One field with a stray strobe before the first line (must be dropped)
    task automatic do_field(input int lines, input int n, input logic f,
                            input logic coinc);
        in_frame_valid = 1'b1;
        tick();
        in_data_valid = 1'b1;
        in_data       = 8'hEE;
        tick();
        in_data_valid = 1'b0;
        tick();
        for (int l = 0; l < lines; l++)
            do_line(n, l, f, 1'b1, coinc && (l == lines - 1));
        in_frame_valid = 1'b0;
        tick();
        tick();
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (video_data_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got addr %0h data %0h expected no pulse",
                             video_address, video_data_in);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_addr", 32'(video_address), 32'(e.addr));
                    check("pix_data", 32'(video_data_in), 32'(e.data));
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        in_frame_valid = 1'b1;
        in_line_valid  = 1'b1;
        in_data_valid  = 1'b1;
        in_data        = 8'h5A;
        tick();
        tick();
        check("rst_frame_valid", 32'(video_frame_valid), 32'd0);
        check("rst_line_valid",  32'(video_line_valid),  32'd0);
        check("rst_data_valid",  32'(video_data_valid),  32'd0);
        check("rst_address",     32'(video_address),     32'd0);
        check("rst_data",        32'(video_data_in),     32'd0);
        check("rst_flags",       32'({pix_overflow, line_overflow}), 32'd0);
        in_frame_valid = 1'b0;
        in_line_valid  = 1'b0;
        in_data_valid  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Field 0: 4 lines x 8 strobes
        do_field(4, 8, 1'b0, 1'b0);
        check("f0_pulses",    32'(pulses),        32'd32);
        check("f0_last_addr", 32'(video_address), 32'h01807);
        check("f0_flags",     32'({pix_overflow, line_overflow}), 32'd0);

        // Field 1: field bit set throughout; address holds after the field
        do_field(4, 8, 1'b1, 1'b0);
        check("f1_pulses",    32'(pulses),        32'd64);
        check("f1_hold_addr", 32'(video_address), 32'h01C07);
        check("f1_hold_valid", 32'(video_data_valid), 32'd0);

        // Overflow field: 6 lines x 10 strobes; cols 8,9 and rows 4,5 dropped
        do_field(6, 10, 1'b0, 1'b0);
        check("ovf_pulses",    32'(pulses),        32'd96);
        check("ovf_last_addr", 32'(video_address), 32'h01807);
        check("ovf_pix_flag",  32'(pix_overflow),  32'(FLAGS_ON));
        check("ovf_line_flag", 32'(line_overflow), 32'(FLAGS_ON));
        tick();
        check("ovf_pix_sticky", 32'(pix_overflow), 32'(FLAGS_ON));

        // Field 1 interrupted by reset in the middle of row 2
        in_frame_valid = 1'b1;
        tick();
        tick();
        do_line(8, 0, 1'b1, 1'b1, 1'b0);
        do_line(8, 1, 1'b1, 1'b1, 1'b0);
        in_line_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data_valid = 1'b1;
            in_data       = pix(2, i, 1'b1);
            push(2, i, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        check("mid_rst_data_valid",  32'(video_data_valid),  32'd0);
        check("mid_rst_address",     32'(video_address),     32'd0);
        check("mid_rst_frame_valid", 32'(video_frame_valid), 32'd0);
        check("mid_rst_line_valid",  32'(video_line_valid),  32'd0);
        check("mid_rst_flags",       32'({pix_overflow, line_overflow}), 32'd0);
        rst = 1'b0;
        for (int i = 3; i < 8; i++) begin
            in_data_valid = 1'b1;
            in_data       = pix(2, i, 1'b1);
            tick();
        end
        in_data_valid = 1'b0;
        tick();
        in_line_valid = 1'b0;
        tick();
        tick();
        do_line(8, 3, 1'b1, 1'b0, 1'b0);
        in_frame_valid = 1'b0;
        tick();
        tick();
        check("mid_rst_pulses", 32'(pulses), 32'd115);

        // First field after reset starts at address 0 with field bit 0
        do_field(1, 3, 1'b0, 1'b0);
        check("post_rst_pulses", 32'(pulses),        32'd118);
        check("post_rst_addr",   32'(video_address), 32'h00002);
        check("post_rst_flags",  32'({pix_overflow, line_overflow}), 32'd0);

        // Line and frame fall together: field still toggles for the next field
        do_field(1, 2, 1'b1, 1'b1);
        check("coinc_addr", 32'(video_address), 32'h00401);
        do_field(2, 1, 1'b0, 1'b0);
        check("after_coinc_addr",   32'(video_address), 32'h00800);
        check("after_coinc_pulses", 32'(pulses),        32'd122);

        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
